// File: rtl/mgc_out_fifo_wait_lvl_edge.sv
// ----------------------------------------------------------------------------
// mgc_out_fifo_wait_lvl_edge
//
// Buffered output port for the edge-detect datapath. A producer-side ld/vd
// handshake writes into a circular buffer and a consumer-side lz/vz handshake
// reads from it. The occupancy (size) and an almost-full flag (afull) are
// exposed so the scheduler can throttle before the buffer fills.
//
// Optional feature: define MGC_OUT_FIFO_BYPASS_EN to let a word written into
// an empty FIFO appear on z/lz in the same cycle (zero-latency cut-through).
// Without the macro every output comes from registers or storage only.
//
// Parameters:
//   rscid     resource ID, informational only
//   width     data width in bits
//   fifo_sz   depth in words, 1..2**ph_log2 (need not be a power of two)
//   ph_log2   pointer width; size is ph_log2+1 bits
//   afull_thr almost-full threshold, 1..fifo_sz
//
// Ports:
//   clk    rising-edge clock
//   arst   asynchronous reset, active-low
//   en     clock enable; while low state holds and vd/lz are forced low
//   ld     producer write request
//   vd     producer ready (space available)
//   d      producer write data
//   lz     consumer valid (data available)
//   vz     consumer ready
//   z      head-of-FIFO data, 0 while empty
//   size   current occupancy
//   afull  high when size >= afull_thr
// ----------------------------------------------------------------------------
module mgc_out_fifo_wait_lvl_edge #(
    parameter int rscid     = 0,
    parameter int width     = 8,
    parameter int fifo_sz   = 8,
    parameter int ph_log2   = 3,
    parameter int afull_thr = 6
) (
    input  logic               clk,
    input  logic               arst,
    input  logic               en,
    input  logic               ld,
    output logic               vd,
    input  logic [width-1:0]   d,
    output logic               lz,
    input  logic               vz,
    output logic [width-1:0]   z,
    output logic [ph_log2:0]   size,
    output logic               afull
);

    localparam int CW = ph_log2 + 1;
    localparam int PW = ph_log2;

    localparam logic [CW-1:0] FULL_CNT  = CW'(fifo_sz);
    localparam logic [CW-1:0] AFULL_CNT = CW'(afull_thr);
    localparam logic [PW-1:0] LAST_PTR  = PW'(fifo_sz - 1);

    logic [width-1:0] mem [0:fifo_sz-1];

    logic [CW-1:0] count;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;

    logic          empty;
    logic          lz_reg;
    logic [width-1:0] z_reg;
    logic          push;
    logic          pop;
    logic          wr;
    logic          rd;

    assign empty  = (count == '0);

    // vd looks only at the registered count, so there is no path from vz.
    assign vd     = en && (count < FULL_CNT);

    assign lz_reg = en && !empty;
    assign z_reg  = empty ? '0 : mem[rd_ptr];

    assign push   = ld && vd;
    assign pop    = lz && vz;

`ifdef MGC_OUT_FIFO_BYPASS_EN
    logic byp;
    logic byp_thru;

    // Empty FIFO with a write pending: present the incoming word directly.
    assign byp      = en && empty && ld;
    // Word consumed in the same cycle it arrives: never touches storage.
    assign byp_thru = byp && vz;

    assign lz = lz_reg || byp;
    assign z  = byp ? d : z_reg;
    assign wr = push && !byp_thru;
    assign rd = pop && !byp_thru;
`else
    assign lz = lz_reg;
    assign z  = z_reg;
    assign wr = push;
    assign rd = pop;
`endif

    assign size  = count;
    assign afull = (count >= AFULL_CNT);

    // Storage is data only and carries no reset; z is masked while empty.
    always_ff @(posedge clk) begin
        if (wr) begin
            mem[wr_ptr] <= d;
        end
    end

    // Pointers wrap explicitly at fifo_sz-1 so odd depths work.
    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else begin
            if (wr) begin
                wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + PW'(1);
            end
            if (rd) begin
                rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + PW'(1);
            end
            case ({wr, rd})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_mgc_out_fifo_wait_lvl_edge.sv
// ----------------------------------------------------------------------------
// Bench for mgc_out_fifo_wait_lvl_edge. Two instances: an 8-deep FIFO with
// almost-full at 6, and a 5-deep FIFO (3-bit pointers, almost-full at 4) to
// exercise non-power-of-two wrap. Stimulus pushes the expected output words
// into per-instance queues; a forked monitor pops and compares whenever the
// consumer handshake completes.
// ----------------------------------------------------------------------------
module tb_mgc_out_fifo_wait_lvl_edge;

    logic       clk;
    logic       arst;
    logic       en;

    logic       ld8, vd8, lz8, vz8, afull8;
    logic [7:0] d8, z8;
    logic [3:0] size8;

    logic       ld5, vd5, lz5, vz5, afull5;
    logic [7:0] d5, z5;
    logic [3:0] size5;

    int n_chk;
    int n_fail;

    logic [7:0] q8[$];
    logic [7:0] q5[$];

    mgc_out_fifo_wait_lvl_edge #(
        .rscid(1), .width(8), .fifo_sz(8), .ph_log2(3), .afull_thr(6)
    ) dut8 (
        .clk(clk), .arst(arst), .en(en),
        .ld(ld8), .vd(vd8), .d(d8),
        .lz(lz8), .vz(vz8), .z(z8),
        .size(size8), .afull(afull8)
    );

    mgc_out_fifo_wait_lvl_edge #(
        .rscid(2), .width(8), .fifo_sz(5), .ph_log2(3), .afull_thr(4)
    ) dut5 (
        .clk(clk), .arst(arst), .en(en),
        .ld(ld5), .vd(vd5), .d(d5),
        .lz(lz5), .vz(vz5), .z(z5),
        .size(size5), .afull(afull5)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Samples just before the rising edge, once inputs and outputs settled.
    task automatic monitor();
        logic [7:0] e;
        forever begin
            @(negedge clk);
            #4;
            if (en && lz8 && vz8) begin
                if (q8.size() == 0) check("pop8_extra", q8.size(), 1);
                else begin
                    e = q8.pop_front();
                    check("z8_order", z8, e);
                end
            end
            if (en && lz5 && vz5) begin
                if (q5.size() == 0) check("pop5_extra", q5.size(), 1);
                else begin
                    e = q5.pop_front();
                    check("z5_order", z5, e);
                end
            end
        end
    endtask

    task automatic cyc8(input logic l, input logic [7:0] dd, input logic v);
        @(negedge clk);
        ld8 = l; d8 = dd; vz8 = v;
        #2;
    endtask

    task automatic cyc5(input logic l, input logic [7:0] dd, input logic v);
        @(negedge clk);
        ld5 = l; d5 = dd; vz5 = v;
        #2;
    endtask

    initial begin
        n_chk = 0; n_fail = 0;
        arst = 1'b0; en = 1'b1;
        ld8 = 0; d8 = 0; vz8 = 0;
        ld5 = 0; d5 = 0; vz5 = 0;

        fork
            monitor();
            begin
                #100000;
                $display("FAIL watchdog: simulation time limit reached");
                $fatal(1, "watchdog");
            end
        join_none

        // 1. Reset and idle
        #2;
        check("rst_vd", vd8, 1);
        check("rst_lz", lz8, 0);
        check("rst_size", size8, 0);
        check("rst_afull", afull8, 0);
        check("rst_z", z8, 0);
        @(negedge clk);
        arst = 1'b1;
        cyc8(0, 8'h00, 0);
        check("idle_vd", vd8, 1);
        check("idle_lz", lz8, 0);
        check("idle_size", size8, 0);
        check("idle_z", z8, 0);

        // 2. Fill to full
        for (int i = 1; i <= 8; i++) begin
            cyc8(1, 8'(i), 0);
            check("fill_size", size8, i - 1);
            check("fill_vd", vd8, 1);
            check("fill_afull", afull8, (i - 1) >= 6);
`ifndef MGC_OUT_FIFO_BYPASS_EN
            if (i == 1) check("fill_no_same_cycle_lz", lz8, 0);
`endif
            q8.push_back(8'(i));
        end
        cyc8(1, 8'h09, 0);
        check("full_size", size8, 8);
        check("full_vd", vd8, 0);
        check("full_afull", afull8, 1);
        check("full_lz", lz8, 1);
        check("full_head", z8, 8'h01);
        cyc8(1, 8'h09, 0);
        check("stall_size", size8, 8);

        // 3. Drain order
        for (int k = 0; k < 8; k++) begin
            cyc8(0, 8'h00, 1);
            check("drain_size", size8, 8 - k);
            check("drain_lz", lz8, 1);
            check("drain_afull", afull8, (8 - k) >= 6);
        end
        cyc8(0, 8'h00, 0);
        check("drained_size", size8, 0);
        check("drained_lz", lz8, 0);
        check("drained_afull", afull8, 0);
        check("drained_z", z8, 0);

        // 4. Concurrent push/pop at count=3
        for (int i = 0; i < 3; i++) begin
            cyc8(1, 8'(8'h10 + i), 0);
            q8.push_back(8'(8'h10 + i));
        end
        for (int i = 0; i < 20; i++) begin
            cyc8(1, 8'(8'h13 + i), 1);
            check("conc_size", size8, 3);
            check("conc_vd", vd8, 1);
            check("conc_lz", lz8, 1);
            q8.push_back(8'(8'h13 + i));
        end
        for (int k = 0; k < 3; k++) begin
            cyc8(0, 8'h00, 1);
            check("conc_drain_size", size8, 3 - k);
            check("conc_drain_lz", lz8, 1);
        end
        cyc8(0, 8'h00, 0);
        check("conc_end_size", size8, 0);

        // 5. Wrap on the 5-deep instance
        for (int r = 0; r < 3; r++) begin
            for (int j = 0; j < 4; j++) begin
                cyc5(1, 8'(r * 16 + j), 0);
                check("wrap_push_size", size5, j);
                q5.push_back(8'(r * 16 + j));
            end
            for (int j = 0; j < 4; j++) begin
                cyc5(0, 8'h00, 1);
                check("wrap_pop_size", size5, 4 - j);
                check("wrap_pop_lz", lz5, 1);
                check("wrap_afull", afull5, (4 - j) >= 4);
            end
            cyc5(0, 8'h00, 0);
            check("wrap_round_empty", size5, 0);
        end
        for (int j = 0; j < 5; j++) begin
            cyc5(1, 8'(8'h50 + j), 0);
            check("odd_fill_size", size5, j);
            check("odd_fill_vd", vd5, 1);
            q5.push_back(8'(8'h50 + j));
        end
        cyc5(1, 8'h5F, 0);
        check("odd_full_size", size5, 5);
        check("odd_full_vd", vd5, 0);
        check("odd_full_afull", afull5, 1);
        for (int j = 0; j < 5; j++) begin
            cyc5(0, 8'h00, 1);
            check("odd_drain_size", size5, 5 - j);
        end
        cyc5(0, 8'h00, 0);
        check("odd_empty", size5, 0);
        check("odd_empty_lz", lz5, 0);

        // 6. Enable low and reset mid-operation
        for (int i = 0; i < 4; i++) begin
            cyc8(1, 8'(8'h30 + i), 0);
            q8.push_back(8'(8'h30 + i));
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            en = 1'b0; ld8 = 1; d8 = 8'h77; vz8 = 1;
            #2;
            check("en0_vd", vd8, 0);
            check("en0_lz", lz8, 0);
            check("en0_size", size8, 4);
            check("en0_afull", afull8, 0);
        end
        @(negedge clk);
        ld8 = 0; vz8 = 0;
        #2;
        check("en0_hold_size", size8, 4);
        arst = 1'b0;
        #1;
        check("arst_size", size8, 0);
        check("arst_lz", lz8, 0);
        check("arst_z", z8, 0);
        check("arst_vd_en0", vd8, 0);
        q8.delete();
        @(negedge clk);
        en = 1'b1;
        #1;
        check("arst_vd_en1", vd8, 1);
        @(negedge clk);
        arst = 1'b1; ld8 = 1; d8 = 8'h44; vz8 = 0;
        q8.push_back(8'h44);
        cyc8(0, 8'h00, 1);
        check("post_rst_size", size8, 1);
        check("post_rst_lz", lz8, 1);
        cyc8(0, 8'h00, 0);
        check("post_rst_empty", size8, 0);

`ifdef MGC_OUT_FIFO_BYPASS_EN
        // Cut-through on an empty FIFO
        cyc8(1, 8'hA5, 1);
        q8.push_back(8'hA5);
        check("byp_lz", lz8, 1);
        check("byp_z", z8, 8'hA5);
        check("byp_size", size8, 0);
        cyc8(0, 8'h00, 0);
        check("byp_after_size", size8, 0);
        check("byp_after_lz", lz8, 0);
`endif

        @(negedge clk);
        #5;
        check("q8_all_popped", q8.size(), 0);
        check("q5_all_popped", q5.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
